// File: rtl/dma_custom_instruction.sv
// -----------------------------------------------------------------------------
// dma_custom_instruction
//
// Custom-instruction front end of the DMA subsystem. Each accepted instruction
// does one read or one write. The target is either a 512 x 32 transfer buffer
// or the DMA configuration register bank. Every accepted instruction completes
// with a single-cycle done pulse.
//
// Ports
//   clock   in   1  system clock, rising edge
//   reset   in   1  asynchronous active-low reset
//   start   in   1  instruction strobe
//   iseId   in   8  instruction ID qualifying start
//   valueA  in  32  write data
//   valueB  in  32  command word:
//                     [0]   is_read
//                     [10]  1 = register bank, 0 = buffer
//                     [9:1] buffer word address
//                     [3:1] register index
//   done    out  1  completion pulse (registered)
//   result  out 32  read data while done = 1, otherwise 0 (registered)
// -----------------------------------------------------------------------------
module dma_custom_instruction #(
  parameter logic [7:0] customInstructionId = 8'd49
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  iseId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RDWAIT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_done;
  logic [31:0] r_result;
  logic [31:0] r_rdata;      // read data staged for the DONE cycle

  // Configuration register bank
  logic [31:0] r_bus_start;
  logic [8:0]  r_buf_start;
  logic [9:0]  r_block_size;
  logic [7:0]  r_burst_size;

  // Transfer buffer
  logic [31:0] r_mem [512];
  logic [31:0] r_ram_q;

  // Command decode
  logic        w_is_read;
  logic        w_is_reg;
  logic [8:0]  w_buf_addr;
  logic [2:0]  w_reg_idx;
  logic        w_accept;
  logic        w_ram_we;
  logic        w_ram_re;
  logic [31:0] w_reg_rdata;
  logic        w_unused;

  assign w_is_read  = valueB[0];
  assign w_is_reg   = valueB[10];
  assign w_buf_addr = valueB[9:1];
  assign w_reg_idx  = valueB[3:1];

  // The upper command bits carry no meaning for this block.
  assign w_unused = &{1'b0, valueB[31:11]};

  assign w_accept = start && (iseId == customInstructionId) && (r_state == S_IDLE);

  // The RAM has no reset, so its write enable is gated by reset directly.
  // A write is then blocked on any edge where reset is already asserted.
  assign w_ram_we = w_accept && !w_is_reg && !w_is_read && reset;
  assign w_ram_re = w_accept && !w_is_reg && w_is_read;

  // Register read mux: narrow registers zero-extend and reserved indices read 0.
  // NOTE: always_comb assigns a default first so that no path can infer a latch.
  always_comb begin
    w_reg_rdata = '0;
    case (w_reg_idx)
      3'd0:    w_reg_rdata = r_bus_start;
      3'd1:    w_reg_rdata = {23'd0, r_buf_start};
      3'd2:    w_reg_rdata = {22'd0, r_block_size};
      3'd3:    w_reg_rdata = {24'd0, r_burst_size};
      default: w_reg_rdata = '0;
    endcase
  end

  // Single-port synchronous buffer RAM.
  // NOTE: the RAM array has no reset on purpose. Its contents must survive a
  // reset, and a reset on the array would prevent mapping it to block RAM.
  always_ff @(posedge clock) begin
    if (w_ram_we) begin
      r_mem[w_buf_addr] <= valueA;
    end
    if (w_ram_re) begin
      r_ram_q <= r_mem[w_buf_addr];
    end
  end

  // Control FSM with registered outputs.
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_done       <= 1'b0;
      r_result     <= '0;
      r_rdata      <= '0;
      r_bus_start  <= '0;
      r_buf_start  <= '0;
      r_block_size <= '0;
      r_burst_size <= '0;
    end else begin
      r_done   <= 1'b0;
      r_result <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_reg && !w_is_read) begin
              case (w_reg_idx)
                3'd0:    r_bus_start  <= valueA;
                3'd1:    r_buf_start  <= valueA[8:0];
                3'd2:    r_block_size <= valueA[9:0];
                3'd3:    r_burst_size <= valueA[7:0];
                default: ;  // reserved: write discarded
              endcase
            end
            // Register reads are resolved now. Writes complete with result 0.
            r_rdata <= (w_is_reg && w_is_read) ? w_reg_rdata : '0;
            // Buffer reads need an extra cycle for the RAM output.
            r_state <= (!w_is_reg && w_is_read) ? S_RDWAIT : S_DONE;
          end
        end
        S_RDWAIT: begin
          r_rdata <= r_ram_q;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done   <= 1'b1;
          r_result <= r_rdata;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_dma_custom_instruction.sv
// -----------------------------------------------------------------------------
// tb_dma_custom_instruction
//
// Directed bench for dma_custom_instruction. A transaction-level model holds
// the register bank and buffer contents. It also tracks when the block is free
// to accept an instruction, and schedules each expected completion as
// (cycle, value) in a queue. A compare process checks done/result on every
// falling edge against that queue. Directed reads additionally pin
// hand-computed values and latencies.
// -----------------------------------------------------------------------------
module tb_dma_custom_instruction;

  localparam logic [7:0] CI_ID = 8'd49;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  iseId;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;   // number of rising edges seen so far
  int last_edge = 0; // edge that sampled the most recent start

  dma_custom_instruction #(.customInstructionId(CI_ID)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .iseId  (iseId),
    .valueA (valueA),
    .valueB (valueB),
    .done   (done),
    .result (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Transaction-level model
  // ---------------------------------------------------------------------------
  typedef struct {
    int          due;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_regs [4];
  logic [31:0] m_buf  [512];
  int          m_free_edge = 0;   // first edge at which a start may be accepted

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_free_edge = 0;
  endtask

  // Apply one accepted instruction to the model; returns result and latency.
  task automatic model_apply(input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] res, output int lat);
    int unsigned idx;
    int unsigned addr;
    idx  = int'(b[3:1]);
    addr = int'(b[9:1]);
    res  = '0;
    lat  = 1;
    if (b[10]) begin
      if (b[0]) begin
        res = (idx < 4) ? m_regs[idx] : 32'd0;
      end else begin
        case (idx)
          0: m_regs[0] = a;
          1: m_regs[1] = a % 512;
          2: m_regs[2] = a % 1024;
          3: m_regs[3] = a % 256;
          default: ;
        endcase
      end
    end else begin
      if (b[0]) begin
        res = m_buf[addr];
        lat = 2;
      end else begin
        m_buf[addr] = a;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    logic        exp_d;
    logic [31:0] exp_r;
    exp_d = 1'b0;
    exp_r = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_d = 1'b1;
      exp_r = exp_q[0].val;
      void'(exp_q.pop_front());
    end
    check("cmp_done", {31'd0, done}, {31'd0, exp_d});
    check("cmp_result", result, exp_r);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers; all start from just after a falling edge
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  // Drive start for one cycle. The model decides whether the block accepts it.
  task automatic issue(input logic [7:0] id, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    int          lat;
    int          edge_n;
    start  = 1'b1;
    iseId  = id;
    valueA = a;
    valueB = b;
    edge_n = cyc + 1;
    last_edge = edge_n;
    if (reset && id == CI_ID && edge_n >= m_free_edge) begin
      model_apply(a, b, res, lat);
      exp_q.push_back('{due: edge_n + lat, val: res});
      m_free_edge = edge_n + lat + 1;
    end
    @(negedge clock);
    #1;
    start  = 1'b0;
    iseId  = '0;
    valueA = '0;
    valueB = '0;
  endtask

  // Read with a hand-computed expected value and latency. The wait is bounded.
  task automatic read_lit(input string name, input logic [31:0] b,
                          input logic [31:0] exp_val, input int exp_lat);
    bit got;
    got = 1'b0;
    issue(CI_ID, 32'd0, b);
    for (int i = 0; i < 6 && !got; i++) begin
      if (done) begin
        got = 1'b1;
        check(name, result, exp_val);
        check({name, "_lat"}, 32'(cyc - last_edge), 32'(exp_lat));
      end else begin
        idle(1);
      end
    end
    if (!got) check({name, "_timeout_done"}, {31'd0, done}, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    iseId  = '0;
    valueA = '0;
    valueB = '0;
    model_reset();
    for (int i = 0; i < 512; i++) m_buf[i] = 'x;

    // Reset state
    idle(3);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b1;
    idle(1);
    read_lit("rst_reg0", 32'h0000_0401, 32'h0000_0000, 1);

    // Register write/read, upper command bits ignored
    issue(CI_ID, 32'h8765_4321, 32'h00FF_FFF0);
    idle(1);
    read_lit("reg0_rd", 32'h00FF_FFF1, 32'h8765_4321, 1);

    // Width masking and reserved register
    issue(CI_ID, 32'hFFFF_FFFF, 32'h0000_0402);
    issue(CI_ID, 32'hFFFF_FFFF, 32'h0000_0402); // lands in DONE: ignored
    issue(CI_ID, 32'hFFFF_FFFF, 32'h0000_0404);
    issue(CI_ID, 32'hFFFF_FFFF, 32'h0000_0404);
    issue(CI_ID, 32'hFFFF_FFFF, 32'h0000_0406);
    issue(CI_ID, 32'hFFFF_FFFF, 32'h0000_0406);
    issue(CI_ID, 32'hFFFF_FFFF, 32'h0000_040A);
    idle(1);
    read_lit("reg1_mask", 32'h0000_0403, 32'h0000_01FF, 1);
    read_lit("reg2_mask", 32'h0000_0405, 32'h0000_03FF, 1);
    read_lit("reg3_mask", 32'h0000_0407, 32'h0000_00FF, 1);
    read_lit("reg5_rsvd", 32'h0000_040B, 32'h0000_0000, 1);

    // Buffer write/read and boundary words
    issue(CI_ID, 32'h1234_5678, 32'h0000_01F0);
    idle(1);
    read_lit("buf_rd", 32'h0000_01F1, 32'h1234_5678, 2);
    issue(CI_ID, 32'hA5A5_0001, 32'h0000_0000);
    idle(1);
    issue(CI_ID, 32'h5A5A_01FF, 32'h0000_03FE);
    idle(1);
    read_lit("buf_w0", 32'h0000_0001, 32'hA5A5_0001, 2);
    read_lit("buf_w511", 32'h0000_03FF, 32'h5A5A_01FF, 2);
    read_lit("buf_hibits", 32'hFFFF_F9F1, 32'h1234_5678, 2);

    // ID filter: no completion and no state change
    issue(8'd48, 32'hDEAD_BEEF, 32'h00FF_FFF0);
    issue(8'd48, 32'h0000_0000, 32'h0000_0401);
    idle(5);
    read_lit("id_filter", 32'h0000_0401, 32'h8765_4321, 1);

    // Matching start during RDWAIT is dropped; only the read completes
    issue(CI_ID, 32'h0000_0000, 32'h0000_01F1);
    issue(CI_ID, 32'h1111_1111, 32'h0000_0400);
    idle(4);
    read_lit("busy_drop", 32'h0000_0401, 32'h8765_4321, 1);

    // Back-to-back: the write is visible to a read accepted during its done cycle
    issue(CI_ID, 32'h0000_0005, 32'h0000_0402);
    issue(CI_ID, 32'h0000_0007, 32'h0000_0402);
    read_lit("b2b_rd", 32'h0000_0403, 32'h0000_0005, 1);

    // Async reset clears done/result immediately, even mid-pulse
    read_lit("pre_rst", 32'h0000_0401, 32'h8765_4321, 1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_done", {31'd0, done}, 32'd0);
    check("async_result", result, 32'd0);
    idle(2);
    reset = 1'b1;
    idle(1);

    // Async reset during RDWAIT aborts with no done; buffer contents survive
    issue(CI_ID, 32'h9999_9999, 32'h0000_0400);
    idle(1);
    issue(CI_ID, 32'h0000_0000, 32'h0000_01F1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("rdwait_rst_done", {31'd0, done}, 32'd0);
    idle(3);
    reset = 1'b1;
    idle(1);
    read_lit("post_rst_reg0", 32'h0000_0401, 32'h0000_0000, 1);
    read_lit("post_rst_buf", 32'h0000_01F1, 32'h1234_5678, 2);

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
